// File: rtl/port_driver_if.sv
// rtl/port_driver_if.sv - command handshake bundle between host and port_driver
interface port_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [31:0] in_payload;

  modport master (output in_valid, in_addr, in_payload, input in_ready);
  modport slave  (input in_valid, in_addr, in_payload, output in_ready);
endinterface

// File: rtl/port_driver.sv
// rtl/port_driver.sv - buffered serializer of {addr, payload} commands onto one router input lane
module port_driver #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1,
  parameter int CNTW  = 16
) (
  input  logic            clock,
  input  logic            reset,
  port_driver_if.slave    cmd,
  input  logic            pause,
  output logic            frame_n,
  output logic            valid_n,
  output logic            di,
  output logic            busy,
  output logic [CNTW-1:0] sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0]     PTR_ONE = 1;
  localparam logic [CNTW-1:0] CNT_ONE = 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAPS} state_t;

  state_t      state;
  logic [35:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [35:0] head;
  logic [34:0] sh;
  logic [5:0]  bcnt;
  logic [GW-1:0] gcnt;
  logic        empty, full, push, start;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cmd.in_ready = !full && !reset;
  assign push  = cmd.in_valid && cmd.in_ready;
  assign head  = mem[rptr[AW-1:0]];
  // A new frame may launch from IDLE or from the final gap cycle, never mid-frame.
  assign start = !empty && !pause &&
                 ((state == IDLE) || ((state == GAPS) && (gcnt == GAP_LAST)));
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= {cmd.in_payload, cmd.in_addr};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)  wptr <= wptr + PTR_ONE;
      if (start) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      frame_n    <= 1'b1;
      valid_n    <= 1'b1;
      di         <= 1'b0;
      sh         <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE, GAPS: begin
          if (start) begin
            sh      <= head[35:1];
            di      <= head[0];
            frame_n <= 1'b0;
            valid_n <= 1'b1;
            bcnt    <= '0;
            state   <= ADDR;
          end else if (state == GAPS) begin
            if (gcnt == GAP_LAST) state <= IDLE;
            else                  gcnt  <= gcnt + 1'b1;
          end
        end
        ADDR: begin
          sh   <= sh >> 1;
          di   <= sh[0];
          bcnt <= bcnt + 6'd1;
          if (bcnt == 6'd3) begin
            valid_n <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bcnt == 6'd35) begin
            frame_n    <= 1'b1;
            valid_n    <= 1'b1;
            di         <= 1'b0;
            sent_count <= sent_count + CNT_ONE;
            gcnt       <= '0;
            state      <= GAPS;
          end else begin
            sh      <= sh >> 1;
            di      <= sh[0];
            bcnt    <= bcnt + 6'd1;
            // frame_n rises on payload bit 31 to mark the last bit.
            frame_n <= (bcnt == 6'd34);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_driver.sv
// tb/tb_port_driver.sv - scoreboard bench for port_driver with a lane receiver model
module tb_port_driver;
  localparam int DEPTH = 4;
  localparam int G     = 2;
  localparam int CW    = 16;
  localparam int PER   = 36 + G;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pause = 1'b0;
  logic          frame_n, valid_n, di, busy;
  logic [CW-1:0] sent_count;

  port_driver_if cmd ();

  port_driver #(.DEPTH(DEPTH), .GAP(G), .CNTW(CW)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .pause(pause),
    .frame_n(frame_n), .valid_n(valid_n), .di(di),
    .busy(busy), .sent_count(sent_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q [$];
  int          starts [$];
  int          rx_done = 0;
  logic [35:0] rx_last = '0;
  int          sc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Receiver model: deserializes the lane and scores each completed frame.
  initial begin : monitor
    int          idx;
    logic [35:0] rsh;
    bit          ok;
    idx = 0; rsh = '0; ok = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        idx = 0;
      end else if (idx == 0) begin
        if (frame_n === 1'b0) begin
          starts.push_back(cyc);
          ok = (valid_n === 1'b1);
          rsh[0] = di;
          idx = 1;
        end
      end else if (frame_n === 1'b1 && valid_n === 1'b1) begin
        idx = 0;
      end else begin
        if (idx < 4) ok &= (frame_n === 1'b0) && (valid_n === 1'b1);
        else         ok &= (valid_n === 1'b0) && (frame_n === (idx == 35));
        rsh[idx] = di;
        idx++;
        if (idx == 36) begin
          idx = 0;
          rx_done++;
          rx_last = rsh;
          check("lane_fmt", ok, 1);
          check("exp_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("frame", rsh, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [31:0] p, output int acc);
    acc = -1;
    cmd.in_valid = 1'b1; cmd.in_addr = a; cmd.in_payload = p;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (cmd.in_ready) begin
        acc = cyc;
        exp_q.push_back({p, a});
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    check("push_accept", acc >= 0, 1);
  endtask

  task automatic stop_push();
    cmd.in_valid = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_sent(input int n, input int limit);
    for (int i = 0; i < limit && sent_count != CW'(n); i++) @(negedge clock);
    check("sent_count", sent_count, n);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    int a, x, n0, p, r0;
    int acc [6];
    logic [3:0] av;
    cmd.in_valid = 1'b0; cmd.in_addr = '0; cmd.in_payload = '0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_in_ready", cmd.in_ready, 0);
    check("rst_frame_n", frame_n, 1);
    check("rst_valid_n", valid_n, 1);
    check("rst_di", di, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_count, 0);
    reset = 1'b0;
    #1 check("rel_in_ready", cmd.in_ready, 1);
    @(negedge clock);

    // single packet timing
    push(4'h5, 32'hA5A5_0F0F, a);
    stop_push();
    check("c1_busy", busy, 1);
    check("c1_lane_idle", frame_n, 1);
    av = 4'h5;
    for (int k = 0; k < 4; k++) begin
      run_to(a + 2 + k);
      check("addr_bit", di, av[k]);
    end
    run_to(a + 37);
    check("b31_frame_n", frame_n, 1);
    check("b31_valid_n", valid_n, 0);
    check("b31_di", di, 1);
    check("b31_sent", sent_count, 0);
    run_to(a + 38);
    check("c38_sent", sent_count, 1);
    run_to(a + 37 + G);
    check("gap_busy", busy, 1);
    run_to(a + 38 + G);
    check("after_gap_busy", busy, 0);
    #1;
    check("single_start", starts.size() > 0 ? starts[starts.size()-1] : -1, a + 2);
    sc = 1;
    wait_idle(100);

    // back-to-back, including a high address
    n0 = starts.size();
    push(4'hC, 32'h1234_5678, a);
    push(4'h0, 32'hFFFF_FFFF, x);
    push(4'hF, 32'h0000_0001, x);
    stop_push();
    wait_sent(sc + 3, 400);
    sc += 3;
    wait_idle(100);
    check("b2b_frames", starts.size() - n0, 3);
    if (starts.size() - n0 == 3) begin
      check("b2b_start0", starts[n0], a + 2);
      check("b2b_start1", starts[n0+1], a + 2 + PER);
      check("b2b_start2", starts[n0+2], a + 2 + 2*PER);
    end

    // full FIFO back-pressure
    for (int i = 0; i < DEPTH + 2; i++) push(4'(i), 32'h1000_0000 + i, acc[i]);
    stop_push();
    check("full_accepts", acc[DEPTH] - acc[0], DEPTH);
    check("full_release", acc[DEPTH+1] - acc[0], 2 + PER);
    wait_sent(sc + DEPTH + 2, 800);
    sc += DEPTH + 2;
    wait_idle(100);

    // pause
    pause = 1'b1;
    #1 n0 = starts.size();
    push(4'h9, 32'hCAFE_0001, x);
    push(4'h2, 32'h0BAD_F00D, x);
    stop_push();
    repeat (10) @(negedge clock);
    #1;
    check("paused_no_frame", starts.size() - n0, 0);
    check("paused_sent", sent_count, sc);
    @(negedge clock);
    pause = 1'b0;
    p = cyc;
    run_to(p + 1);
    #1;
    check("unpause_frame_n", frame_n, 0);
    check("unpause_start", starts.size() > n0 ? starts[starts.size()-1] : -1, p + 1);
    run_to(p + 15);
    pause = 1'b1;
    wait_sent(sc + 1, 100);
    sc += 1;
    repeat (20) @(negedge clock);
    #1;
    check("pause_hold", starts.size() - n0, 1);
    check("pause_busy", busy, 1);
    @(negedge clock);
    pause = 1'b0;
    wait_sent(sc + 1, 200);
    sc += 1;
    wait_idle(100);

    // reset mid-packet
    push(4'h7, 32'h7777_0000, a);
    push(4'h8, 32'h8888_0000, x);
    push(4'h6, 32'h6666_0000, x);
    stop_push();
    run_to(a + 21);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("mid_rst_frame_n", frame_n, 1);
    check("mid_rst_valid_n", valid_n, 1);
    check("mid_rst_di", di, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sent", sent_count, 0);
    check("mid_rst_in_ready", cmd.in_ready, 0);
    reset = 1'b0;
    sc = 0;
    #1 n0 = starts.size();
    repeat (100) @(negedge clock);
    #1;
    check("post_rst_frames", starts.size() - n0, 0);
    check("post_rst_sent", sent_count, 0);
    check("post_rst_busy", busy, 0);

    // loopback
    @(negedge clock);
    r0 = rx_done;
    push(4'h3, 32'hDEAD_BEEF, x);
    stop_push();
    wait_sent(1, 100);
    wait_idle(100);
    check("loop_vld_once", rx_done - r0, 1);
    check("loop_word", rx_last, {32'hDEAD_BEEF, 4'h3});

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/port_driver.md
# port_driver

Serial packet transmitter for the router's input-port protocol. It accepts {address, payload} commands on a parallel valid/ready interface and buffers them in a small FIFO. Each command is serialized onto one router input lane (frame_n, valid_n, di) with a 4-bit address phase, a 32-bit payload phase and a programmable inter-packet gap. It sits on the host/testbench side of each router input and is the source end of the lane that the router's input port receives.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2
- GAP, 1, idle cycles driven between packets; ≥1
- CNTW, 16, width of sent_count

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while reset is high
- in_addr  in  4  destination address
- in_payload  in  32  payload word
- pause  in  1  when high, no new packet starts; an in-flight packet always completes
- frame_n  out  1  lane frame strobe, active low
- valid_n  out  1  lane payload-valid strobe, active low
- di  out  1  lane serial data
- busy  out  1  FSM not IDLE or FIFO non-empty
- sent_count  out  CNTW  packets completed, wraps modulo 2^CNTW

## Operation
- Accept on a rising edge with in_valid & in_ready. The FIFO stores {in_addr, in_payload}. in_valid while full is ignored, with no side effect.
- FSM states:
  - IDLE: frame_n=1, valid_n=1, di=0. If FIFO non-empty and !pause: pop the head into the shift register and go to ADDR.
  - ADDR: 4 cycles, frame_n=0, valid_n=1, di=addr[0..3] LSB first.
  - DATA: 32 cycles, valid_n=0, di=payload[0..31] LSB first. frame_n=0 for bits 0–30 and frame_n=1 for bit 31, which marks the last bit.
  - GAP: GAP cycles with idle levels. On the last GAP cycle, if FIFO non-empty and !pause, pop and enter ADDR directly; otherwise go to IDLE.
- The frame never stalls. Every address and payload bit occupies exactly one cycle, because any extra cycle would be mis-sampled by the receiver.
- All lane outputs are registered.
- sent_count increments on the edge that ends the payload[31] cycle.
- busy is combinational from state and FIFO empty.
- Simultaneous push and pop on the same edge is legal when not full. Occupancy is unchanged.
- Addresses 8–15 are transmitted unchanged. Range checking is the sender's job.
- Reset mid-packet: outputs return to idle levels on the next edge, the FIFO is flushed, the FSM returns to IDLE and sent_count is cleared. The truncated frame is not resumed.

## Timing
- Reset values: frame_n=1, valid_n=1, di=0, in_ready=0 while reset is high (1 in the first cycle after release), busy=0, sent_count=0.
- Numbering: acceptance edge ends cycle 0, FSM idle and FIFO empty before it.
  - Cycle 1: lane still idle, FIFO non-empty, busy=1.
  - Cycles 2–5: address bits 0–3.
  - Cycles 6–36: payload bits 0–30.
  - Cycle 37: payload bit 31 with frame_n=1, valid_n=0.
  - Cycles 38..37+GAP: idle.
- Latency from acceptance to first address bit is 2 cycles. A frame is 36 lane cycles.
- Back-to-back packets with the FIFO non-empty are separated by exactly GAP idle cycles. Period is 36+GAP.
- pause is sampled only in IDLE and on the last GAP cycle. Raising it during ADDR or DATA has no effect on the current frame.
- With the FIFO full, in_ready rises the cycle after the pop edge.

## Test plan
- Single packet: addr=4'h5, payload=32'hA5A5_0F0F, GAP=1. Required lane sequence:
  - cycles 2–5 di=1,0,1,0 with frame_n=0, valid_n=1;
  - then payload LSB-first, valid_n=0, frame_n=1 only on bit 31 (di=1);
  - sent_count=1 after cycle 37; busy=0 from cycle 39.
- Back-to-back: 3 commands pushed on consecutive cycles, GAP=2 -> frames start at cycles 2, 40, 78. Exactly 2 idle cycles between frames. sent_count=3.
- Full FIFO: push DEPTH+1 commands continuously -> in_ready=0 after DEPTH+1 accepts, since the first is popped at cycle 1. The extra command is held off, no entry is lost, and all are transmitted in order.
- Pause: assert pause with 2 queued commands, then deassert after 10 cycles -> no frame starts while paused. The first address bit appears 1 cycle after pause falls. A pause asserted mid-DATA does not truncate the frame.
- Reset mid-packet: reset high in cycle 20 of a frame with 2 queued commands:
  - next cycle: frame_n=1, valid_n=1, di=0, busy=0, sent_count=0;
  - no further frames without new pushes.
- Loopback into a router input port model for addr=3, payload=32'hDEAD_BEEF -> receiver addr=3, payload=32'hDEAD_BEEF, vld asserted once.
